// File: rtl/risc_pkg.sv
// Shared encodings for the accumulator-CPU control sequencer: opcodes,
// instruction phases, top-level states and the datapath strobe bundle.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HALTED  = 2'd2
  } top_state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
    logic instr_done;
  } strobes_t;

  // Opcodes that read memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_strobe_dec.sv
// Combinational strobe decoder: maps (state, phase, opcode, zero) of the
// upcoming cycle onto the datapath strobe vector.
module risc_strobe_dec
  import risc_pkg::*;
(
  input  top_state_t next_state,
  input  logic [2:0] next_phase,
  input  logic [2:0] opcode,
  input  logic       zero,
  output strobes_t   strobes
);

  logic alu;

  always_comb begin
    strobes = '0;
    alu     = is_aluop(opcode);
    case (next_state)
      ST_EXEC: begin
        case (next_phase)
          PH_INST_ADDR: strobes.sel = 1'b1;
          PH_INST_FETCH: begin
            strobes.sel = 1'b1;
            strobes.rd  = 1'b1;
          end
          PH_INST_LOAD, PH_IDLE: begin
            strobes.sel   = 1'b1;
            strobes.rd    = 1'b1;
            strobes.ld_ir = 1'b1;
          end
          PH_OP_ADDR:  strobes.inc_pc = 1'b1;
          PH_OP_FETCH: strobes.rd     = alu;
          // zero only matters here, i.e. it is consumed at the end of OP_FETCH
          PH_ALU_OP: begin
            strobes.rd     = alu;
            strobes.inc_pc = (opcode == OP_SKZ) && zero;
            strobes.ld_pc  = (opcode == OP_JMP);
            strobes.data_e = (opcode == OP_STO);
          end
          PH_STORE: begin
            strobes.rd         = alu;
            strobes.ld_ac      = alu;
            strobes.ld_pc      = (opcode == OP_JMP);
            strobes.wr         = (opcode == OP_STO);
            strobes.data_e     = (opcode == OP_STO);
            strobes.instr_done = 1'b1;
          end
          default: strobes = '0;
        endcase
      end
      ST_HALTED: strobes.halt = 1'b1;
      default:   strobes = '0;
    endcase
  end

endmodule

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle control sequencer: run/step/halt management, 8-phase
// instruction stepping, registered datapath strobes and retired counter.
module risc_seq_ctrl
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  top_state_t       state_r, next_state;
  logic [2:0]       phase_r, next_phase;
  logic             step_r, next_step;
  strobes_t         strobes_r, strobes_s;
  logic [CNT_W-1:0] retired_r;

  // Top-state / phase sequencing.
  always_comb begin
    next_state = state_r;
    next_phase = phase_r;
    next_step  = step_r;
    case (state_r)
      ST_STOPPED: begin
        if (run || step) begin
          next_state = ST_EXEC;
          next_phase = PH_INST_ADDR;
          next_step  = step & ~run;
        end else begin
          next_phase = PH_INST_ADDR;
        end
      end
      ST_EXEC: begin
        if ((phase_r == PH_OP_ADDR) && (opcode == OP_HLT)) begin
          next_state = ST_HALTED;
          next_phase = PH_INST_ADDR;
          next_step  = 1'b0;
        end else if (phase_r == PH_STORE) begin
          next_phase = PH_INST_ADDR;
          if (!(run && !step_r)) begin
            next_state = ST_STOPPED;
            next_step  = 1'b0;
          end else begin
            next_state = ST_EXEC;
          end
        end else begin
          next_phase = phase_r + 3'd1;
        end
      end
      ST_HALTED: begin
        next_phase = PH_INST_ADDR;
        if (!run) begin
          next_state = ST_STOPPED;
        end else begin
          next_state = ST_HALTED;
        end
      end
      default: begin
        next_state = ST_STOPPED;
        next_phase = PH_INST_ADDR;
        next_step  = 1'b0;
      end
    endcase
  end

  risc_strobe_dec u_dec (
    .next_state (next_state),
    .next_phase (next_phase),
    .opcode     (opcode),
    .zero       (zero),
    .strobes    (strobes_s)
  );

  // State, phase, step flag, strobe and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_STOPPED;
      phase_r   <= 3'd0;
      step_r    <= 1'b0;
      strobes_r <= '0;
      retired_r <= '0;
    end else begin
      state_r   <= next_state;
      phase_r   <= next_phase;
      step_r    <= next_step;
      strobes_r <= strobes_s;
      if ((next_state == ST_EXEC) && (next_phase == PH_STORE)) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  assign sel        = strobes_r.sel;
  assign rd         = strobes_r.rd;
  assign wr         = strobes_r.wr;
  assign ld_ir      = strobes_r.ld_ir;
  assign ld_ac      = strobes_r.ld_ac;
  assign ld_pc      = strobes_r.ld_pc;
  assign inc_pc     = strobes_r.inc_pc;
  assign data_e     = strobes_r.data_e;
  assign halt       = strobes_r.halt;
  assign instr_done = strobes_r.instr_done;
  assign phase      = phase_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Scoreboard bench for risc_seq_ctrl: per-instruction strobe masks are queued
// at issue and compared by a monitor when instr_done pulses.
module tb_risc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, step, zero;
  logic [2:0]  opcode;
  logic        sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_done;
  logic [2:0]  phase;
  logic [15:0] retired;
  logic        s_sel, s_rd, s_wr, s_ld_ir, s_ld_ac, s_ld_pc, s_inc_pc, s_data_e, s_halt, s_done;
  logic [2:0]  s_phase;
  logic [1:0]  s_retired;

  risc_seq_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase),
    .instr_done(instr_done), .retired(retired)
  );

  risc_seq_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero),
    .sel(s_sel), .rd(s_rd), .wr(s_wr), .ld_ir(s_ld_ir), .ld_ac(s_ld_ac), .ld_pc(s_ld_pc),
    .inc_pc(s_inc_pc), .data_e(s_data_e), .halt(s_halt), .phase(s_phase),
    .instr_done(s_done), .retired(s_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e;
    logic [15:0] ret;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] m_sel, m_rd, m_wr, m_ld_ir, m_ld_ac, m_ld_pc, m_inc_pc, m_data_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_ret  = 0;

  logic [2:0] vec_op [0:13] = '{3'd5, 3'd5, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd1, 3'd7,
                                3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
  logic       vec_z  [0:13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_done};
  endfunction

  // Hand-derived phase masks (bit i = strobe during phase i).
  task automatic push_exp(input logic [2:0] op, input logic z);
    exp_t e;
    exp_ret++;
    e.sel = 8'h0F; e.ld_ir = 8'h0C; e.rd = 8'h0E; e.wr = 8'h00;
    e.ld_ac = 8'h00; e.ld_pc = 8'h00; e.inc_pc = 8'h10; e.data_e = 8'h00;
    case (op)
      3'd2, 3'd3, 3'd4, 3'd5: begin e.rd = 8'hEE; e.ld_ac = 8'h80; end
      3'd6: begin e.wr = 8'h80; e.data_e = 8'hC0; end
      3'd1: e.inc_pc = z ? 8'h50 : 8'h10;
      3'd7: e.ld_pc = 8'hC0;
      default: ;
    endcase
    e.ret = exp_ret[15:0];
    q.push_back(e);
  endtask

  task automatic wait_phase(input logic [2:0] p, input string tag);
    int  k = 0;
    logic hit = 1'b0;
    while (!hit && k < 64) begin
      @(negedge clk);
      k++;
      hit = (phase == p) && ((p != 3'd0) || sel);
    end
    if (!hit) check({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int  k = 0;
    logic hit = 1'b0;
    while (!hit && k < 64) begin
      @(negedge clk);
      k++;
      hit = instr_done;
    end
    if (!hit) check({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic run_vectors(input int first, input int n);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_phase(3'd0, "vec_phase0");
      opcode = vec_op[first+i];
      zero   = vec_z[first+i];
      push_exp(vec_op[first+i], vec_z[first+i]);
    end
    wait_done("vec_last_done");
    run = 1'b0;
  endtask

  // Monitor: capture strobes per phase, compare queued masks at instr_done.
  always @(negedge clk) begin
    if (rst) begin
      m_sel[phase] = sel;       m_rd[phase] = rd;         m_wr[phase] = wr;
      m_ld_ir[phase] = ld_ir;   m_ld_ac[phase] = ld_ac;   m_ld_pc[phase] = ld_pc;
      m_inc_pc[phase] = inc_pc; m_data_e[phase] = data_e;
      check("rd_wr_exclusive", 32'(rd & wr), 32'd0);
      check("ldpc_incpc_exclusive", 32'(ld_pc & inc_pc), 32'd0);
      if (instr_done) begin
        if (q.size() == 0) begin
          check("unexpected_instr_done", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("done_phase", 32'(phase), 32'd7);
          check("mask_sel", 32'(m_sel), 32'(mon_e.sel));
          check("mask_rd", 32'(m_rd), 32'(mon_e.rd));
          check("mask_wr", 32'(m_wr), 32'(mon_e.wr));
          check("mask_ld_ir", 32'(m_ld_ir), 32'(mon_e.ld_ir));
          check("mask_ld_ac", 32'(m_ld_ac), 32'(mon_e.ld_ac));
          check("mask_ld_pc", 32'(m_ld_pc), 32'(mon_e.ld_pc));
          check("mask_inc_pc", 32'(m_inc_pc), 32'(mon_e.inc_pc));
          check("mask_data_e", 32'(m_data_e), 32'(mon_e.data_e));
          check("retired", 32'(retired), 32'(mon_e.ret));
        end
      end
    end
  end

  initial begin
    int sel_cnt;
    rst = 1'b1; run = 1'b0; step = 1'b0; zero = 1'b0; opcode = 3'd5;
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("stopped_idle", 32'({outs(), phase}), 32'd0);

    // Continuous run over all ALU/branch/store opcodes.
    run_vectors(0, 9);
    @(negedge clk);
    check("stopped_after_run", 32'({sel, halt, phase}), 32'd0);

    // HLT with run held high.
    opcode = 3'd0; run = 1'b1;
    wait_phase(3'd4, "hlt_phase4");
    check("hlt_inc_pc_ph4", 32'({inc_pc, halt}), 32'b10);
    @(negedge clk);
    check("halted_outs", 32'(outs()), 32'b10);
    check("halted_retired", 32'(retired), 32'(exp_ret));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halted_hold", 32'(outs()), 32'b10);
    end
    run = 1'b0;
    @(negedge clk);
    check("halt_exit_outs", 32'(outs()), 32'd0);
    check("halt_exit_phase", 32'(phase), 32'd0);

    // Single step, second step mid-instruction ignored.
    opcode = 3'd2; step = 1'b1;
    push_exp(3'd2, 1'b0);
    @(negedge clk);
    step = 1'b0;
    wait_phase(3'd3, "step_phase3");
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_done("step_done");
    sel_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sel || phase != 3'd0) sel_cnt++;
    end
    check("step_single_instr", 32'(sel_cnt), 32'd0);
    check("step_queue_empty", 32'(q.size()), 32'd0);

    // Asynchronous reset in ALU_OP of a STO.
    opcode = 3'd6; run = 1'b1;
    wait_phase(3'd6, "sto_phase6");
    check("sto_ph6_rd_wr_de", 32'({rd, wr, data_e}), 32'b001);
    rst = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs()), 32'd0);
    check("async_reset_phase", 32'(phase), 32'd0);
    check("async_reset_retired", 32'(retired), 32'd0);
    run = 1'b0; exp_ret = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_stopped", 32'({outs(), phase}), 32'd0);

    // Five instructions: 16-bit counter reads 5, 2-bit counter wraps to 1.
    run_vectors(9, 5);
    @(negedge clk);
    check("retired_16", 32'(retired), 32'd5);
    check("retired_wrap_2b", 32'(s_retired), 32'd1);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_seq_ctrl.md
Name: risc_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 8-bit accumulator CPU.
- Steps each instruction through 8 fixed phases and decodes the 3-bit opcode from the instruction register.
- Drives the datapath strobes: address mux, memory read/write, IR/PC/AC loads, data bus enable.
- Adds run / single-step / halt management and a retired-instruction counter. Sits between IR/ALU-zero and the datapath inside risc_cpu.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- run  in  1  level; 1 = execute continuously.
- step  in  1  one-cycle pulse; execute exactly one instruction from STOPPED.
- opcode  in  3  IR[7:5]; stable from phase IDLE onward.
- zero  in  1  accumulator-zero flag.
- sel  out  1  address mux: 1 = PC, 0 = IR operand field.
- rd  out  1  memory read.
- wr  out  1  memory write.
- ld_ir  out  1  load instruction register.
- ld_ac  out  1  load accumulator.
- ld_pc  out  1  load PC (jump).
- inc_pc  out  1  increment PC.
- data_e  out  1  drive AC onto data bus.
- halt  out  1  1 while in HALTED.
- phase  out  3  current phase index (debug).
- instr_done  out  1  one-cycle pulse in STORE of every completed instruction.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Top states: STOPPED, EXEC (phase 0..7), HALTED.
- Reset (rst=0): state STOPPED, phase=0, retired=0. All outputs 0. Reset takes effect immediately, including mid-instruction.
- STOPPED -> EXEC phase 0 when run=1 or step=1. Both together are treated as run. The step flag is latched for this instruction only.
- EXEC phases and strobes; all strobes are registered, computed from next state, and valid during the named phase:
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc. For HLT, next state is HALTED; the PC is still incremented.
  - 5 OP_FETCH: rd if ALUOP.
  - 6 ALU_OP: rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
  - 7 STORE: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO; instr_done=1; retired+1.
- After STORE:
  - -> phase 0 if run=1 and the latched step flag is 0.
  - Otherwise -> STOPPED, clearing the step flag.
- step while in EXEC or HALTED is ignored.
- HALTED: all strobes 0, halt=1. HLT does not pulse instr_done and does not count.
  - Exits to STOPPED when run=0 (sampled each cycle).
  - run held high keeps the CPU halted.
- zero is sampled at the end of phase 5; opcode is sampled from phase 3 onward. Changes at other times must not affect strobes.
- Never assert rd and wr together. Never assert ld_pc and inc_pc together.
- retired wraps from 2^CNT_W-1 to 0.

Decomposition:
- risc_pkg holds:
  - opcode localparams (HLT..JMP);
  - phase encodings (INST_ADDR..STORE);
  - top-state encodings.
- Sub-module risc_strobe_dec: combinational (next_state, phase, opcode, zero) -> strobe vector, registered in the parent. It is unit-testable against the phase table.

Test Plan:
- Reset, run=1, opcode=LDA, zero=0 -> phases 0..7 repeat with period 8. rd asserted in phases 1,2,3,5,6,7; ld_ac only in phase 7; retired=1 after the first STORE.
- opcode=STO, run=1 -> wr and data_e in phase 7; data_e alone in phase 6; rd never asserted in phases 5–7.
- opcode=SKZ: zero=1 -> inc_pc in phases 4 and 6; zero=0 -> inc_pc in phase 4 only. opcode=JMP -> ld_pc in phases 6 and 7, no inc_pc there.
- opcode=HLT with run=1 -> halt=1 from the cycle after phase 4, strobes 0, retired unchanged. Hold run=1 for 20 cycles -> stays HALTED. run=0 -> STOPPED; then step pulse -> exactly one 8-phase instruction -> STOPPED.
- From STOPPED, step pulse with opcode=ADD -> one instruction, instr_done pulses once, retired+1, returns to STOPPED. A second step pulse issued mid-instruction is ignored.
- Drive rst=0 during phase 6 of an STO -> wr, data_e, and all outputs drop to 0 before the next clock edge; phase=0, state STOPPED. CNT_W=2 after 5 instructions -> retired=1.
